exception_branch_unit: RTL and testbench
========================================

Name: exception_branch_unit

Overview:
- Consumer end of the $r30 (rstatus) exception protocol. Overflowing add/addi/sub write codes 1/2/3 into $r30, and setx writes T into $r30.
- The block keeps a committed shadow of $r30 and resolves bex in the DX stage using forwarded status.
- When bex is taken, it issues a PC redirect plus a timed fetch/decode squash. It also counts exceptions for debug.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_fd/flush_dx stay high after a taken bex (1..7).
- CNT_W, 16, width of the saturating exception counter.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- dx_ir  in  32  instruction in DX stage
- dx_valid  in  1  DX instruction is live (not a bubble)
- xm_ir  in  32  instruction in XM stage (post-exception rewrite)
- xm_o  in  32  XM result value (post-exception rewrite)
- mw_ir  in  32  instruction in MW stage
- mw_data  in  32  MW writeback data
- stall_bex  out  1  hold PC/FD/DX this cycle
- redirect  out  1  one-cycle pulse: load PC with redirect_pc
- redirect_pc  out  32  zero-extended T of the taken bex
- flush_fd  out  1  squash FD latch
- flush_dx  out  1  squash DX latch
- rstatus  out  32  committed shadow of $r30
- exc_count  out  CNT_W  saturating count of committed exception codes 1..3

Behaviour:
- Opcodes:
  - ALU = 00000, ADDI = 00101, LW = 01000, SETX = 10101, BEX = 10110.
  - rd = ir[26:22]; T = ir[26:0].
- Writes-r30 predicate W(ir) is true when either:
  - opcode is ALU/ADDI/LW and rd==30; or
  - opcode is SETX.
- Write value:
  - SETX: {5'b0, T}.
  - Otherwise: xm_o when evaluated at XM, mw_data when evaluated at MW.
- Shadow register:
  - On each rising edge, if W(mw_ir), rstatus <= mw value.
  - If mw value ∈ {1,2,3}, exc_count increments, saturating at all-ones.
- Forwarded status S (combinational), highest priority first:
  1. W(xm_ir): the XM value.
  2. W(mw_ir): the MW value.
  3. rstatus.
- Load hazard:
  - stall_bex = dx_valid & opcode(dx_ir)==BEX & opcode(xm_ir)==LW & rd(xm_ir)==30 & state==IDLE.
  - Combinational; no redirect in a stalled cycle.
- FSM states: IDLE, SQUASH. The squash counter is 3 bits.
  - IDLE: a taken bex requires dx_valid & BEX & !stall_bex & S!=0.
    - redirect=1 and redirect_pc={5'b0,T} combinationally in the same cycle.
    - flush_fd=flush_dx=1 in the same cycle.
    - Next state SQUASH with cnt=FLUSH_CYCLES-1.
    - If FLUSH_CYCLES==1, stay in IDLE.
  - SQUASH: flush_fd=flush_dx=1 and redirect=0.
    - BEX in DX is ignored (it is on the squashed path).
    - cnt decrements; leave for IDLE when cnt==1.
  - Total flush window is FLUSH_CYCLES cycles, including the redirect cycle.
- A not-taken bex (S==0) produces no outputs; the pipeline proceeds.
- Simultaneous events:
  - MW commit and a DX bex read in the same cycle: bex uses the forwarded MW value, not the old rstatus.
  - A setx in XM forwards over an older exception code in MW.
- Reset (asserted at any time, including mid-SQUASH):
  - rstatus=0, exc_count=0, state=IDLE, cnt=0.
  - redirect, flush_fd, flush_dx, stall_bex=0 immediately.
- Outputs other than rstatus/exc_count are combinational from state and inputs. rstatus and exc_count are registered.

Decomposition:
- Shared package holds:
  - opcode constants (ALU, ADDI, LW, SETX, BEX);
  - RSTATUS_REG=30;
  - exception code constants EXC_ADD=1, EXC_ADDI=2, EXC_SUB=3;
  - the FSM state typedef.
- One sub-module is natural: r30_write_decode. It computes W(ir) and the SETX value, and is instantiated for XM and MW.

Test Plan:
- Shadow update: MW ADD with rd=30, mw_data=1, then DX bex T=0x100 with no XM/MW writes. Required: rstatus=1, redirect pulse with redirect_pc=0x100, flush high exactly 2 cycles, exc_count=1.
- XM forwarding: rstatus=0, xm_ir=ADDI rd=30, xm_o=2, DX bex T=0x40. Required: redirect same cycle, redirect_pc=0x40.
- Not taken / setx zero: xm_ir=SETX T=0, mw_ir has rd=30 with data=3. Required: XM wins, S=0, no redirect, no flush.
- LW hazard: xm_ir=LW rd=30 with DX bex. Required: stall_bex=1 for one cycle. Next cycle the LW is in MW with mw_data=5; required: redirect taken.
- Squash ignore and reset: a taken bex, then another bex in DX during SQUASH. Required: no second redirect. Assert reset_n=0 mid-SQUASH; required: flushes drop immediately, rstatus=0, exc_count=0.
- Saturation: force 2^CNT_W+3 commits of code 3. Required: exc_count holds at 0xFFFF; commit of code 7 does not increment.

Source files
------------

// File: rtl/exception_branch_unit_pkg.sv
// Shared opcodes, exception codes and FSM state type for the $r30 status
// consumer (bex resolution, shadow register, exception counter).
package exception_branch_unit_pkg;
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] RSTATUS_REG = 5'd30;

  localparam logic [31:0] EXC_ADD  = 32'd1;
  localparam logic [31:0] EXC_ADDI = 32'd2;
  localparam logic [31:0] EXC_SUB  = 32'd3;

  typedef enum logic {ST_IDLE, ST_SQUASH} ebu_state_e;

  function automatic logic [4:0] opcode(input logic [31:0] ir);
    return ir[31:27];
  endfunction
endpackage

// File: rtl/exception_branch_unit_if.sv
// Pipeline-facing bundle of the exception/branch unit: stage instructions
// and values in, bex control and status out.
interface exception_branch_unit_if #(parameter int CNT_W = 16);
  logic [31:0]      dx_ir;
  logic             dx_valid;
  logic [31:0]      xm_ir;
  logic [31:0]      xm_o;
  logic [31:0]      mw_ir;
  logic [31:0]      mw_data;
  logic             stall_bex;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_fd;
  logic             flush_dx;
  logic [31:0]      rstatus;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output dx_ir, dx_valid, xm_ir, xm_o, mw_ir, mw_data,
    input  stall_bex, redirect, redirect_pc, flush_fd, flush_dx, rstatus, exc_count
  );

  modport slave (
    input  dx_ir, dx_valid, xm_ir, xm_o, mw_ir, mw_data,
    output stall_bex, redirect, redirect_pc, flush_fd, flush_dx, rstatus, exc_count
  );
endinterface

// File: rtl/exception_branch_unit_r30_write_decode.sv
// Decides whether a stage's instruction writes $r30 and with what value;
// setx carries its value in the immediate, everything else uses the stage result.
module r30_write_decode
  import exception_branch_unit_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [31:0] stage_val,
  output logic        w,
  output logic [31:0] wval
);
  logic [4:0] op;
  logic       rd_is_r30;

  always_comb begin
    op        = opcode(ir);
    rd_is_r30 = (ir[26:22] == RSTATUS_REG);
    w         = ((op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW)) ? rd_is_r30
              : (op == OP_SETX);
    wval      = (op == OP_SETX) ? {5'b0, ir[26:0]} : stage_val;
  end
endmodule

// File: rtl/exception_branch_unit.sv
// Keeps the committed $r30 shadow, resolves bex in DX with XM/MW forwarding,
// and sequences the PC redirect plus fetch/decode squash window.
module exception_branch_unit
  import exception_branch_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  exception_branch_unit_if.slave  bus
);
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  logic             xm_w, mw_w;
  logic [31:0]      xm_val, mw_val;
  logic [31:0]      status;
  logic             dx_bex, xm_lw_r30;
  logic             stall, redirect, flush;

  ebu_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      rstatus_q, rstatus_d;
  logic [CNT_W-1:0] exc_count_q, exc_count_d;

  r30_write_decode u_xm_dec (.ir(bus.xm_ir), .stage_val(bus.xm_o),    .w(xm_w), .wval(xm_val));
  r30_write_decode u_mw_dec (.ir(bus.mw_ir), .stage_val(bus.mw_data), .w(mw_w), .wval(mw_val));

  always_comb begin
    rstatus_d   = rstatus_q;
    exc_count_d = exc_count_q;
    if (mw_w) begin
      rstatus_d = mw_val;
      if ((mw_val inside {EXC_ADD, EXC_ADDI, EXC_SUB}) && (exc_count_q != '1))
        exc_count_d = exc_count_q + 1'b1;
    end
  end

  // Youngest writer wins: XM over MW over the committed shadow.
  always_comb begin
    if (xm_w)      status = xm_val;
    else if (mw_w) status = mw_val;
    else           status = rstatus_q;
  end

  always_comb begin
    dx_bex    = bus.dx_valid && (opcode(bus.dx_ir) == OP_BEX);
    xm_lw_r30 = (opcode(bus.xm_ir) == OP_LW) && (bus.xm_ir[26:22] == RSTATUS_REG);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    redirect = 1'b0;
    flush    = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_IDLE: begin
          stall = dx_bex && xm_lw_r30;
          if (dx_bex && !stall && (status != 32'd0)) begin
            redirect = 1'b1;
            flush    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_SQUASH;
              cnt_d   = CNT_INIT;
            end
          end
        end
        ST_SQUASH: begin
          // Anything in DX here is on the squashed path, bex included.
          flush = 1'b1;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      rstatus_q   <= 32'd0;
      exc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rstatus_q   <= rstatus_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign bus.stall_bex   = stall;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = {5'b0, bus.dx_ir[26:0]};
  assign bus.flush_fd    = flush;
  assign bus.flush_dx    = flush;
  assign bus.rstatus     = rstatus_q;
  assign bus.exc_count   = exc_count_q;
endmodule

// File: tb/tb_exception_branch_unit.sv
// Directed test-plan scenarios plus random pipeline traffic, checked each
// cycle against a flush-window/commit reference model.
module tb_exception_branch_unit;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  exception_branch_unit_if #(.CNT_W(CNT_W)) bus ();

  exception_branch_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int unsigned m_rs;
  int          m_cnt;
  int          m_left;   // flush cycles still owed after the current one

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_w(input logic [31:0] ir);
    int op = int'(ir[31:27]);
    int rd = int'(ir[26:22]);
    return ((op == 0 || op == 5 || op == 8) && rd == 30) || op == 21;
  endfunction

  function automatic logic [31:0] m_val(input logic [31:0] ir, input logic [31:0] v);
    return (ir[31:27] == 5'd21) ? (ir & 32'h07FF_FFFF) : v;
  endfunction

  function automatic logic [31:0] mk(input int op, input int rd, input int low);
    logic [31:0] r;
    r = {5'(op), 5'(rd), 22'(low)};
    return r;
  endfunction

  task automatic nop_all();
    bus.dx_ir = 32'd0; bus.dx_valid = 1'b0;
    bus.xm_ir = 32'd0; bus.xm_o = 32'd0;
    bus.mw_ir = 32'd0; bus.mw_data = 32'd0;
  endtask

  task automatic model_reset();
    m_rs = 0; m_cnt = 0; m_left = 0;
  endtask

  // Compare at negedge, advance the model at posedge, return 1ns later.
  task automatic cycle();
    logic [31:0] s;
    bit dx_bex, stall, taken, flush;
    @(negedge clock);
    if (m_w(bus.xm_ir))      s = m_val(bus.xm_ir, bus.xm_o);
    else if (m_w(bus.mw_ir)) s = m_val(bus.mw_ir, bus.mw_data);
    else                     s = m_rs;
    dx_bex = bus.dx_valid && bus.dx_ir[31:27] == 5'd22;
    stall  = (m_left == 0) && dx_bex && bus.xm_ir[31:27] == 5'd8 && bus.xm_ir[26:22] == 5'd30;
    taken  = (m_left == 0) && dx_bex && !stall && s != 0;
    flush  = taken || (m_left > 0);
    chk("stall_bex", 32'(bus.stall_bex), 32'(stall));
    chk("redirect",  32'(bus.redirect),  32'(taken));
    chk("flush_fd",  32'(bus.flush_fd),  32'(flush));
    chk("flush_dx",  32'(bus.flush_dx),  32'(flush));
    chk("rstatus",   bus.rstatus,        m_rs);
    chk("exc_count", 32'(bus.exc_count), 32'(m_cnt));
    if (taken) chk("redirect_pc", bus.redirect_pc, bus.dx_ir & 32'h07FF_FFFF);
    @(posedge clock);
    if (m_w(bus.mw_ir)) begin
      m_rs = m_val(bus.mw_ir, bus.mw_data);
      if (m_rs >= 1 && m_rs <= 3 && m_cnt < CNT_MAX) m_cnt++;
    end
    if (taken)           m_left = FLUSH_CYCLES - 1;
    else if (m_left > 0) m_left--;
    #1;
  endtask

  function automatic logic [31:0] rnd_ir();
    int k, rd;
    k  = $urandom_range(0, 6);
    rd = ($urandom_range(0, 1) == 1) ? 30 : $urandom_range(0, 31);
    case (k)
      0: return mk(0, rd, $urandom);
      1: return mk(5, rd, $urandom);
      2: return mk(8, rd, $urandom);
      3: return ($urandom_range(0, 2) == 0) ? mk(21, 0, 0) : mk(21, rd, $urandom_range(0, 3));
      4, 5: return mk(22, rd, $urandom);
      default: return mk($urandom_range(0, 31), rd, $urandom);
    endcase
  endfunction

  initial begin
    model_reset();
    nop_all();
    #2;
    chk("rst_rstatus",  bus.rstatus, 32'd0);
    chk("rst_count",    32'(bus.exc_count), 32'd0);
    chk("rst_flush",    32'(bus.flush_fd), 32'd0);
    chk("rst_redirect", 32'(bus.redirect), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // shadow update then bex from committed status
    bus.mw_ir = mk(0, 30, 0); bus.mw_data = 32'd1; cycle();
    nop_all(); bus.dx_ir = mk(22, 0, 32'h100); bus.dx_valid = 1'b1; cycle();
    nop_all(); cycle(); cycle();
    chk("t1_rstatus", bus.rstatus, 32'd1);
    chk("t1_count",   32'(bus.exc_count), 32'd1);

    // XM forwarding with zero shadow
    reset_n = 1'b0; #1; model_reset(); @(negedge clock); reset_n = 1'b1; @(posedge clock); #1;
    bus.xm_ir = mk(5, 30, 0); bus.xm_o = 32'd2;
    bus.dx_ir = mk(22, 0, 32'h40); bus.dx_valid = 1'b1; cycle();
    nop_all(); cycle(); cycle();

    // setx T=0 in XM overrides exception code in MW: not taken
    bus.xm_ir = mk(21, 0, 0); bus.mw_ir = mk(0, 30, 0); bus.mw_data = 32'd3;
    bus.dx_ir = mk(22, 0, 32'h80); bus.dx_valid = 1'b1; cycle();
    nop_all(); cycle();

    // LW hazard: stall, then forwarded MW value resolves the bex
    bus.xm_ir = mk(8, 30, 0); bus.dx_ir = mk(22, 0, 32'h20); bus.dx_valid = 1'b1; cycle();
    bus.xm_ir = 32'd0; bus.mw_ir = mk(8, 30, 0); bus.mw_data = 32'd5; cycle();
    nop_all();
    // bex in DX during SQUASH must be ignored
    bus.dx_ir = mk(22, 0, 32'h333); bus.dx_valid = 1'b1;
    bus.xm_ir = mk(21, 0, 7);
    cycle();
    // taken bex, then reset mid-squash
    cycle();
    reset_n = 1'b0; #1;
    chk("rst_mid_flush_fd", 32'(bus.flush_fd), 32'd0);
    chk("rst_mid_flush_dx", 32'(bus.flush_dx), 32'd0);
    chk("rst_mid_redirect", 32'(bus.redirect), 32'd0);
    chk("rst_mid_stall",    32'(bus.stall_bex), 32'd0);
    chk("rst_mid_rstatus",  bus.rstatus, 32'd0);
    chk("rst_mid_count",    32'(bus.exc_count), 32'd0);
    model_reset();
    nop_all();
    @(negedge clock); reset_n = 1'b1; @(posedge clock); #1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.dx_ir = rnd_ir(); bus.dx_valid = 1'($urandom_range(0, 3) != 0);
      bus.xm_ir = rnd_ir(); bus.xm_o = $urandom_range(0, 5);
      bus.mw_ir = rnd_ir(); bus.mw_data = $urandom_range(0, 5);
      cycle();
    end

    // saturation of the exception counter
    nop_all();
    bus.mw_ir = mk(0, 30, 0); bus.mw_data = 32'd3;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle();
    chk("sat_count", 32'(bus.exc_count), 32'hFFFF);
    bus.mw_data = 32'd7; cycle(); cycle();
    chk("sat_code7_count",   32'(bus.exc_count), 32'hFFFF);
    chk("sat_code7_rstatus", bus.rstatus, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
